// File: rtl/alu_result_serializer.sv
// Buffers packed dual-ALU result words in a small FIFO and shifts each one out on a single pad
// as a framed stream: start bit (low), DATA_W bits MSB first, stop bit (high).
module alu_result_serializer #(
  parameter int DATA_W  = 27,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     ser_out,
  output logic                     ser_frame,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [1:0]               fsm_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [DATA_W-1:0]   shift;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                push;
  logic                pop;
  logic                div_end;

  // Handshake: a word transfers on any edge where in_valid && in_ready. in_ready comes only from
  // the registered level, so a word offered while full is dropped even if a pop happens that cycle.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign pop       = (level != '0) && ((state == IDLE) || ((state == STOP) && div_end));
  assign fsm_state = state;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // Outputs are set on the transition edge so the line value always matches the state it enters.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      shift     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      ser_out   <= 1'b1;
      ser_frame <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_out   <= 1'b1;
          ser_frame <= 1'b0;
          div_cnt   <= '0;
          if (pop) begin
            shift     <= mem[rd_ptr];
            state     <= START;
            ser_out   <= 1'b0;
            ser_frame <= 1'b1;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (div_end) begin
            div_cnt <= '0;
            bit_cnt <= BIT_W'(DATA_W - 1);
            state   <= DATA;
            ser_out <= shift[DATA_W-1];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (div_end) begin
            div_cnt <= '0;
            if (bit_cnt == '0) begin
              state     <= STOP;
              ser_out   <= 1'b1;
              ser_frame <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              shift   <= shift << 1;
              ser_out <= shift[DATA_W-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (div_end) begin
            div_cnt <= '0;
            if (pop) begin
              shift     <= mem[rd_ptr];
              state     <= START;
              ser_out   <= 1'b0;
              ser_frame <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: a frame monitor checks every serial cycle against words
// queued by the drivers; a second instance runs with a one-cycle bit time.
module tb_alu_result_serializer;

  localparam int DATA_W  = 27;
  localparam int DEPTH   = 4;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = (DATA_W + 2) * CLK_DIV;
  localparam int FRAME1  = DATA_W + 2;

  logic                  clk;
  logic                  rst;
  logic                  in_valid, in_valid1;
  logic [DATA_W-1:0]     in_data, in_data1;
  logic                  in_ready, in_ready1;
  logic                  ser_out, ser_out1;
  logic                  ser_frame, ser_frame1;
  logic                  busy, busy1;
  logic [$clog2(DEPTH):0] level, level1;
  logic                  overflow, overflow1;
  logic [1:0]            fsm_state, fsm_state1;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_q1[$];
  int                start_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int frames_done = 0;

  alu_result_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ser_out(ser_out), .ser_frame(ser_frame), .busy(busy),
    .level(level), .overflow(overflow), .fsm_state(fsm_state)
  );

  alu_result_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLK_DIV(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .ser_out(ser_out1), .ser_frame(ser_frame1), .busy(busy1),
    .level(level1), .overflow(overflow1), .fsm_state(fsm_state1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic logic exp_line(input logic [DATA_W-1:0] w, input int slot);
    if (slot == 0) return 1'b0;
    else if (slot <= DATA_W) return w[DATA_W-slot];
    else return 1'b1;
  endfunction

  task automatic go_to(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input bit accepted);
    in_valid = 1'b1;
    in_data  = w;
    if (accepted) exp_q.push_back(w);
    @(negedge clk);
  endtask

  // Frame monitor for the CLK_DIV instance: pops the expected word at each start bit
  int                mon_pos = 0;
  bit                in_frame = 1'b0;
  logic [DATA_W-1:0] cur_word = '0;
  logic [DATA_W-1:0] rx_word  = '0;

  always @(posedge clk) begin
    #1;
    edge_cnt++;
    if (rst) begin
      in_frame = 1'b0;
      mon_pos  = 0;
    end else begin
      if (!in_frame) begin
        if (ser_frame === 1'b1 && ser_out === 1'b0) begin
          in_frame = 1'b1;
          mon_pos  = 0;
          rx_word  = '0;
          start_q.push_back(edge_cnt);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(exp_q.size()), 32'd1);
            cur_word = '0;
          end else begin
            cur_word = exp_q.pop_front();
          end
        end else begin
          check("idle_ser_out", 32'(ser_out), 32'd1);
          check("idle_ser_frame", 32'(ser_frame), 32'd0);
        end
      end
      if (in_frame) begin
        check("ser_out", 32'(ser_out), 32'(exp_line(cur_word, mon_pos / CLK_DIV)));
        check("ser_frame", 32'(ser_frame), 32'((mon_pos / CLK_DIV) <= DATA_W));
        if ((mon_pos / CLK_DIV) >= 1 && (mon_pos / CLK_DIV) <= DATA_W && (mon_pos % CLK_DIV) == 0)
          rx_word = {rx_word[DATA_W-2:0], ser_out};
        if (mon_pos == FRAME - 1) begin
          check("rx_word", 32'(rx_word), 32'(cur_word));
          frames_done++;
          in_frame = 1'b0;
        end
        mon_pos++;
      end
    end
  end

  int                t0, t1, fd0, si;
  logic [DATA_W-1:0] w6 [6];
  logic [DATA_W-1:0] cur1;
  int                slot1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;

    // 1: reset held for several edges
    repeat (3) @(negedge clk);
    check("rst_ser_out", 32'(ser_out), 32'd1);
    check("rst_ser_frame", 32'(ser_frame), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2: single word, latency and frame length
    t0 = edge_cnt; fd0 = frames_done; si = start_q.size();
    push_word(27'h5A5A5A5, 1'b1);
    in_valid = 1'b0;
    check("t2_level_c1", 32'(level), 32'd1);
    check("t2_busy_c1", 32'(busy), 32'd0);
    go_to(t0 + 2);
    check("t2_busy_c2", 32'(busy), 32'd1);
    check("t2_level_c2", 32'(level), 32'd0);
    go_to(t0 + FRAME + 1);
    check("t2_busy_last_stop", 32'(busy), 32'd1);
    go_to(t0 + FRAME + 2);
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_frames", 32'(frames_done - fd0), 32'd1);
    if (start_q.size() > si) check("t2_start_cycle", 32'(start_q[si] - t0), 32'd2);
    else check("t2_start_seen", 32'(start_q.size() - si), 32'd1);

    // 3: three back-to-back words
    repeat (3) @(negedge clk);
    t0 = edge_cnt; fd0 = frames_done; si = start_q.size();
    push_word(27'($urandom), 1'b1);
    check("t3_level_c1", 32'(level), 32'd1);
    push_word(27'($urandom), 1'b1);
    check("t3_level_c2", 32'(level), 32'd1);
    push_word(27'($urandom), 1'b1);
    in_valid = 1'b0;
    check("t3_level_c3", 32'(level), 32'd2);
    go_to(t0 + 3 * FRAME + 2);
    check("t3_frames", 32'(frames_done - fd0), 32'd3);
    check("t3_level_end", 32'(level), 32'd0);
    check("t3_busy_end", 32'(busy), 32'd0);
    if (start_q.size() >= si + 3) begin
      check("t3_start0", 32'(start_q[si] - t0), 32'd2);
      for (int k = 0; k < 2; k++)
        check("t3_contiguous", 32'(start_q[si+k+1] - start_q[si+k]), 32'(FRAME));
    end else begin
      check("t3_starts_seen", 32'(start_q.size() - si), 32'd3);
    end

    // 4: overflow with in_valid held six cycles
    repeat (3) @(negedge clk);
    t0 = edge_cnt; fd0 = frames_done;
    for (int i = 0; i < 6; i++) w6[i] = 27'($urandom);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("t4_ready_c4", 32'(in_ready), 32'd1);
      push_word(w6[i], 1'b1);
    end
    check("t4_level_c5", 32'(level), 32'(DEPTH));
    check("t4_ready_c5", 32'(in_ready), 32'd0);
    check("t4_ovf_c5", 32'(overflow), 32'd0);
    push_word(w6[5], 1'b0);
    in_valid = 1'b0;
    check("t4_ovf_c6", 32'(overflow), 32'd1);
    go_to(t0 + 5 * FRAME + 2);
    check("t4_frames", 32'(frames_done - fd0), 32'd5);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    check("t4_level_end", 32'(level), 32'd0);

    // 5: reset during data bit 10 of a frame with another word queued
    repeat (3) @(negedge clk);
    t0 = edge_cnt; fd0 = frames_done;
    push_word(27'($urandom), 1'b1);
    push_word(27'($urandom), 1'b1);
    in_valid = 1'b0;
    go_to(t0 + 2 + CLK_DIV * 11 + 1);
    check("t5_pre_level", 32'(level), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ser_out", 32'(ser_out), 32'd1);
    check("t5_ser_frame", 32'(ser_frame), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    t1 = edge_cnt; si = start_q.size();
    push_word(27'($urandom), 1'b1);
    in_valid = 1'b0;
    go_to(t1 + FRAME + 2);
    check("t5_frames", 32'(frames_done - fd0), 32'd1);
    if (start_q.size() > si) check("t5_start_cycle", 32'(start_q[si] - t1), 32'd2);
    else check("t5_start_seen", 32'(start_q.size() - si), 32'd1);

    // 6: one-cycle bit time, two frames back to back
    repeat (2) @(negedge clk);
    t0 = edge_cnt;
    in_valid1 = 1'b1; in_data1 = 27'h7FFFFFF; exp_q1.push_back(27'h7FFFFFF);
    @(negedge clk);
    in_data1 = 27'h5A5A5A5; exp_q1.push_back(27'h5A5A5A5);
    cur1 = '0;
    for (int c = 1; c <= 2 * FRAME1 + 3; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) in_valid1 = 1'b0;
      if (c < 2 || c > 2 * FRAME1 + 1) begin
        check("t6_idle_out", 32'(ser_out1), 32'd1);
        check("t6_idle_frame", 32'(ser_frame1), 32'd0);
      end else begin
        slot1 = (c - 2) % FRAME1;
        if (slot1 == 0) begin
          if (exp_q1.size() != 0) cur1 = exp_q1.pop_front();
          else check("t6_queue", 32'(exp_q1.size()), 32'd1);
        end
        check("t6_ser_out", 32'(ser_out1), 32'(exp_line(cur1, slot1)));
        check("t6_ser_frame", 32'(ser_frame1), 32'(slot1 <= DATA_W));
      end
      if (c == 2 * FRAME1 + 1) check("t6_busy_last", 32'(busy1), 32'd1);
      if (c == 2 * FRAME1 + 2) check("t6_busy_after", 32'(busy1), 32'd0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_q1_empty", 32'(exp_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
